// File: rtl/seq_tx.sv
// seq_tx: serial pattern transmitter for the overlapping run detector.
// Loads a parallel word and shifts it out MSB first, one bit per clock.
// Alongside each bit it produces run_flag, which is the result a correct
// overlapping RUN_LEN-run detector must give for the same stream.
// Optional feature macro: SEQ_TX_PARITY_EN adds an even-parity bit to
// the end of every frame.
//
// Handshake: a load is accepted on a rising edge where load=1 and
// ready=1. ready is a registered output. It is high in IDLE and on the
// last bit of a frame, and low otherwise. A load that arrives while
// ready=0 is dropped and is not queued.
module seq_tx #(
  parameter int WIDTH   = 8,
  parameter int RUN_LEN = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             ready,
  output logic             out,
  output logic             out_valid,
  output logic             run_flag,
  output logic             done,
  output logic             o_dbg_state
);

`ifdef SEQ_TX_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CW = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam int RW = $clog2(RUN_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(FRAME - 1);
  localparam logic [RW-1:0] RMAX = RW'(RUN_LEN);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t          r_state;
  logic [FRAME-1:0] r_shift;
  logic [CW-1:0]   r_cnt;
  logic [RW-1:0]   r_run;
  logic            r_out, r_valid, r_flag, r_done, r_ready;

  state_t          w_state_nxt;
  logic [FRAME-1:0] w_shift_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [RW-1:0]   w_run_nxt;
  logic            w_out_nxt, w_valid_nxt, w_flag_nxt, w_done_nxt, w_ready_nxt;
  logic [FRAME-1:0] w_frame;
  logic            w_accept, w_last, w_have, w_bit;

`ifdef SEQ_TX_PARITY_EN
  assign w_frame = {data_in, ^data_in};
`else
  assign w_frame = data_in;
`endif

  assign w_accept = load && r_ready;
  assign w_last   = (r_state == SHIFT) && (r_cnt == LAST);

  // Next-state and next-output logic. All outputs are computed one cycle
  // ahead so that the port values come straight from registers.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_have      = 1'b0;
    w_bit       = 1'b0;
    w_run_nxt   = '0;
    w_out_nxt   = 1'b0;
    w_valid_nxt = 1'b0;
    w_flag_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_ready_nxt = 1'b1;

    if (w_accept) begin
      // New frame from IDLE, or back-to-back on the last bit.
      w_state_nxt = SHIFT;
      w_bit       = w_frame[FRAME-1];
      w_shift_nxt = w_frame << 1;
      w_cnt_nxt   = '0;
      w_have      = 1'b1;
    end else if ((r_state == SHIFT) && !w_last) begin
      w_bit       = r_shift[FRAME-1];
      w_shift_nxt = r_shift << 1;
      w_cnt_nxt   = r_cnt + CW'(1);
      w_have      = 1'b1;
    end else begin
      w_state_nxt = IDLE;
      w_shift_nxt = '0;
      w_cnt_nxt   = '0;
    end

    if (w_have) begin
      w_out_nxt   = w_bit;
      w_valid_nxt = 1'b1;
      // Run history carries across a back-to-back boundary because r_valid
      // is still high. After IDLE, r_valid=0 restarts the count at 1.
      if (r_valid && (w_bit == r_out))
        w_run_nxt = (r_run == RMAX) ? RMAX : r_run + RW'(1);
      else
        w_run_nxt = RW'(1);
      w_flag_nxt  = (w_run_nxt == RMAX);
      w_done_nxt  = (w_cnt_nxt == LAST);
      w_ready_nxt = (w_cnt_nxt == LAST);
    end
  end

  // State and output registers, with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_run   <= '0;
      r_out   <= 1'b0;
      r_valid <= 1'b0;
      r_flag  <= 1'b0;
      r_done  <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
      r_run   <= w_run_nxt;
      r_out   <= w_out_nxt;
      r_valid <= w_valid_nxt;
      r_flag  <= w_flag_nxt;
      r_done  <= w_done_nxt;
      r_ready <= w_ready_nxt;
    end
  end

  assign ready       = r_ready;
  assign out         = r_out;
  assign out_valid   = r_valid;
  assign run_flag    = r_flag;
  assign done        = r_done;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_seq_tx.sv
// Testbench for seq_tx. It runs directed frames with literal expectations
// and then randomized traffic. A queue-based reference model predicts the
// outputs, and the outputs are compared against it on every falling edge.
module tb_seq_tx;
  localparam int WIDTH   = 8;
  localparam int RUN_LEN = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] data_in = '0;
  logic             load = 1'b0;
  logic             ready, out, out_valid, run_flag, done, dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  seq_tx #(.WIDTH(WIDTH), .RUN_LEN(RUN_LEN)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .load(load),
    .ready(ready), .out(out), .out_valid(out_valid), .run_flag(run_flag),
    .done(done), .o_dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // rem_q holds the frame bits still to be sent. hist_q holds the recent
  // valid bits since the last IDLE.
  logic rem_q[$];
  logic hist_q[$];
  logic m_out = 1'b0, m_valid = 1'b0, m_flag = 1'b0, m_done = 1'b0, m_ready = 1'b1;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem_q.delete(); hist_q.delete();
      m_out = 0; m_valid = 0; m_flag = 0; m_done = 0; m_ready = 1;
    end else begin
      logic b;
      b = 1'b0;
      if (load && m_ready) begin
        for (int i = WIDTH - 1; i >= 0; i--) rem_q.push_back(data_in[i]);
`ifdef SEQ_TX_PARITY_EN
        rem_q.push_back(^data_in);
`endif
      end
      if (rem_q.size() > 0) begin
        b = rem_q.pop_front();
        m_valid = 1; m_out = b;
        hist_q.push_back(b);
        if (hist_q.size() > RUN_LEN) void'(hist_q.pop_front());
      end else begin
        m_valid = 0; m_out = 0;
        hist_q.delete();
      end
      m_done  = m_valid && (rem_q.size() == 0);
      m_ready = !m_valid || (rem_q.size() == 0);
      m_flag  = 0;
      if (m_valid && hist_q.size() == RUN_LEN) begin
        m_flag = 1;
        foreach (hist_q[k]) if (hist_q[k] != b) m_flag = 0;
      end
    end
  end

  // scoreboard helper
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // compare process: every falling edge
  always @(negedge clk) begin
    chk("cyc_out",   {31'd0, out},       {31'd0, m_out});
    chk("cyc_valid", {31'd0, out_valid}, {31'd0, m_valid});
    chk("cyc_flag",  {31'd0, run_flag},  {31'd0, m_flag});
    chk("cyc_done",  {31'd0, done},      {31'd0, m_done});
    chk("cyc_ready", {31'd0, ready},     {31'd0, m_ready});
  end

  // ---------------- driver tasks ----------------
  task automatic start(input logic [WIDTH-1:0] d);
    @(posedge clk); #1;
    load = 1'b1; data_in = d;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  // Sample n cycles at falling edges, first cycle in the MSB of the result.
  // If inj_idx>=0, load is raised with inj_d for one cycle starting at
  // that sample.
  task automatic capture(input int n, input int inj_idx, input logic [WIDTH-1:0] inj_d,
                         output logic [31:0] bits, output logic [31:0] flags,
                         output logic [31:0] dones, output logic [31:0] valids);
    bits = '0; flags = '0; dones = '0; valids = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bits   = {bits[30:0], out};
      flags  = {flags[30:0], run_flag};
      dones  = {dones[30:0], done};
      valids = {valids[30:0], out_valid};
      if (i == inj_idx) begin load = 1'b1; data_in = inj_d; end
      else load = 1'b0;
    end
    load = 1'b0;
  endtask

  logic [31:0] b, f, dn, v;

  initial begin
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out",   {31'd0, out}, 32'd0);
    chk("rst_state", {31'd0, dbg_state}, 32'd0);
    #1 reset = 1'b1;

`ifdef SEQ_TX_PARITY_EN
    start(8'hE5);
    capture(9, -1, 8'h00, b, f, dn, v);
    chk("par_out",  b,  32'b111001011);
    chk("par_flag", f,  32'b001000000);
    chk("par_done", dn, 32'b000000001);
`else
    // Frame E5
    start(8'hE5);
    capture(8, -1, 8'h00, b, f, dn, v);
    chk("e5_out",  b,  32'b11100101);
    chk("e5_flag", f,  32'b00100000);
    chk("e5_done", dn, 32'b00000001);
    @(negedge clk);
    chk("e5_idle_ready", {31'd0, ready}, 32'd1);
    chk("e5_idle_valid", {31'd0, out_valid}, 32'd0);

    // Frame 8F: overlapping 000 and 111
    start(8'h8F);
    capture(8, -1, 8'h00, b, f, dn, v);
    chk("8f_out",  b, 32'b10001111);
    chk("8f_flag", f, 32'b00010011);

    // Back-to-back FF then 80
    start(8'hFF);
    capture(16, 7, 8'h80, b, f, dn, v);
    chk("b2b_out",   b,  32'hFF80);
    chk("b2b_flag",  f,  32'h3F9F);
    chk("b2b_valid", v,  32'hFFFF);
    chk("b2b_done",  dn, 32'h0101);

    // A load while ready=0 is ignored
    repeat (2) @(negedge clk);
    start(8'hA5);
    capture(11, 3, 8'h00, b, f, dn, v);
    chk("ign_out",   b, 32'b10100101000);
    chk("ign_valid", v, 32'b11111111000);

    // Asynchronous reset at bit 4 of F0
    start(8'hF0);
    capture(4, -1, 8'h00, b, f, dn, v);
    chk("ar_pre_out",  b, 32'b1111);
    chk("ar_pre_flag", f, 32'b0011);
    #1 reset = 1'b0;
    #1;
    chk("ar_out",   {31'd0, out},       32'd0);
    chk("ar_valid", {31'd0, out_valid}, 32'd0);
    chk("ar_flag",  {31'd0, run_flag},  32'd0);
    chk("ar_done",  {31'd0, done},      32'd0);
    chk("ar_ready", {31'd0, ready},     32'd1);
    @(negedge clk); #1 reset = 1'b1;
    start(8'h0F);
    capture(8, -1, 8'h00, b, f, dn, v);
    chk("ar_new_out",  b, 32'b00001111);
    chk("ar_new_flag", f, 32'b00110011);
`endif

    // Randomized traffic with occasional asynchronous resets
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      load    = ($urandom_range(0, 3) != 0);
      data_in = WIDTH'($urandom);
      if ($urandom_range(0, 79) == 0) begin
        #2 reset = 1'b0;
        @(negedge clk); #1 reset = 1'b1;
      end
    end
    load = 1'b0;
    repeat (12) @(negedge clk);
    chk("end_idle_valid", {31'd0, out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/seq_tx.md
Name: seq_tx

Overview:
Serial pattern transmitter: the driving end of the single-bit `in` stream consumed by the team's overlapping 111/000 run detector.
- Accepts a parallel word over a valid/ready handshake and shifts it out MSB first, one bit per clock.
- Generates `run_flag`, the reference result a correct overlapping detector must produce for the transmitted stream.
- Lets benches drive and self-check the detector from one block.

Parameters:
WIDTH, 8, data word width in bits (>= 2).
RUN_LEN, 3, length of the identical-bit run that sets run_flag (>= 2).

Ports:
clk  input  1  clock, rising-edge active.
reset  input  1  reset, asynchronous, active-low (0 = reset).
data_in  input  WIDTH  word to transmit; sampled on an accepted load.
load  input  1  request to transmit data_in.
ready  output  1  block can accept a load this cycle.
out  output  1  serial bit; drives the detector `in`.
out_valid  output  1  out carries a frame bit this cycle.
run_flag  output  1  the last RUN_LEN valid bits, including the current one, are all equal.
done  output  1  one-cycle pulse on the last bit of a frame.

Behaviour:
- Reset (reset=0, asynchronous) forces the following; all are also cleared mid-frame, and the frame is abandoned with no done pulse:
  - state=IDLE
  - out=0, out_valid=0, run_flag=0, done=0, ready=1
  - shift register=0, bit counter=0, run counter=0
- States:
  - IDLE: ready=1, out_valid=0, out=0, run_flag=0. If load=1, capture data_in and go to SHIFT.
  - SHIFT: out_valid=1.
    - The first SHIFT cycle presents data_in[WIDTH-1] (latency: 1 cycle from the load edge).
    - Each cycle shifts left by one; the frame lasts exactly WIDTH cycles.
  - Last bit (counter=WIDTH-1): done=1, ready=1.
    - load=1 here: capture the new word; the next cycle presents its MSB (back-to-back, no gap). Run history is kept across the boundary.
    - Otherwise: go to IDLE; the run counter clears on entry to IDLE.
- ready=0 during SHIFT except the last bit. A load while ready=0 is ignored and does not queue.
- Run tracking:
  - run_cnt counts consecutive equal valid bits and saturates at RUN_LEN.
  - First bit after IDLE: run_cnt=1.
  - Bit equal to the previous bit: run_cnt=min(run_cnt+1, RUN_LEN). Otherwise run_cnt=1.
  - run_flag=1 in the same cycle as the bit whenever run_cnt=RUN_LEN. This gives overlapping behaviour: 1111 flags the 3rd and 4th bits.
- All outputs are registered; none depend combinationally on load or data_in.
- done, out_valid and run_flag are never high in IDLE.

Optional Feature:
- Macro: SEQ_TX_PARITY_EN.
- Defined:
  - Each frame is WIDTH+1 bits; the final bit is even parity, the XOR of all data bits.
  - done and the back-to-back ready window move to the parity bit.
  - The parity bit participates in run tracking.
- Undefined: frame is exactly WIDTH data bits; no parity logic is synthesised.

Test Plan:
1. Reset release, then load data_in=8'hE5 for one cycle.
   - out over 8 cycles = 1,1,1,0,0,1,0,1.
   - run_flag = 0,0,1,0,0,0,0,0.
   - done high on cycle 8 only, then IDLE with ready=1.
2. Load 8'h8F.
   - out = 1,0,0,0,1,1,1,1.
   - run_flag = 0,0,0,1,0,0,1,1 (overlapping 000 and 111 both flagged).
3. Back-to-back: load 8'hFF, then hold load=1 with 8'h80 on the done cycle.
   - 16 contiguous valid bits: 1x9 then 0x7.
   - run_flag high on stream bits 3-9 and 12-16; no out_valid gap.
4. Load pulsed while ready=0 mid-frame (data 8'h00).
   - Ignored: the current frame completes unchanged.
   - IDLE follows with no second frame.
5. reset=0 asynchronously at bit 4 of 8'hF0.
   - All outputs 0 and ready=1 immediately, without waiting for a clock edge.
   - After release, a new load of 8'h0F transmits from its MSB with run history cleared.
6. SEQ_TX_PARITY_EN defined, load 8'hE5.
   - 9 bits: 1,1,1,0,0,1,0,1,1.
   - done on bit 9.
   - run_flag = 0,0,1,0,0,0,0,0,0.
